// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan decoder.
// Segment patterns are active-low, ordered abcdefg (bit 6 = a, bit 0 = g).
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Code reported for blank or unrecognised slots.
    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    // Per-slot qualification state.
    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURED
    } scan_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-low segment pattern to BCD.
// Blank (all segments off) is flagged separately and is not an error.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] bcd,
    output logic       is_blank,
    output logic       is_err
);

    // Pattern lookup; anything outside the table is invalid.
    always_comb begin
        bcd      = DIGIT_INVALID;
        is_blank = 1'b0;
        is_err   = 1'b0;
        case (seg_n)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: is_blank = 1'b1;
            default:   is_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low 7-segment bus, qualifies each digit slot
// for stability, and publishes complete decoded frames with dp/blank/error info.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_n,
    input  logic                    dp_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic                    stale
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_MAX  = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    // Registered sample S and previous sample S'
    logic [6:0]            s_seg, p_seg;
    logic                  s_dp, p_dp;
    logic [NUM_DIGITS-1:0] s_an, p_an;

    logic [NUM_DIGITS-1:0] an_sel;
    logic                  an_ok;
    logic                  same;

    logic [3:0] dec_bcd;
    logic       dec_blank;
    logic       dec_err;

    scan_state_e   state_q, state_d;
    logic [CW-1:0] count_q, count_d, count_inc;
    logic          capture;

    logic [4*NUM_DIGITS-1:0] slot_code_q, slot_code_d;
    logic [NUM_DIGITS-1:0]   slot_dp_q, slot_dp_d;
    logic [NUM_DIGITS-1:0]   slot_blank_q, slot_blank_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;

    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    stale_q, stale_d;

    assign an_sel    = ~s_an;
    assign an_ok     = $onehot(an_sel);
    assign same      = ({s_seg, s_dp, s_an} == {p_seg, p_dp, p_an});
    assign count_inc = count_q + CW'(1);

    seg7_to_bcd u_dec (
        .seg_n    (s_seg),
        .bcd      (dec_bcd),
        .is_blank (dec_blank),
        .is_err   (dec_err)
    );

    // Input sample register and one-deep history; resets to an idle bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_seg <= SEG_BLANK;
            s_dp  <= 1'b1;
            s_an  <= '1;
            p_seg <= SEG_BLANK;
            p_dp  <= 1'b1;
            p_an  <= '1;
        end else begin
            s_seg <= seg_n;
            s_dp  <= dp_n;
            s_an  <= an_n;
            p_seg <= s_seg;
            p_dp  <= s_dp;
            p_an  <= s_an;
        end
    end

    // Stability FSM: capture once per settled digit, re-arm on any change.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (an_ok) begin
                    state_d = SETTLE;
                    count_d = CW'(1);
                end
            end
            SETTLE: begin
                if (!an_ok) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (!same) begin
                    count_d = CW'(1);
                end else if (count_inc == STABLE_MAX) begin
                    capture = 1'b1;
                    state_d = CAPTURED;
                    count_d = '0;
                end else begin
                    count_d = count_inc;
                end
            end
            CAPTURED: begin
                if (!an_ok) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (!same) begin
                    state_d = SETTLE;
                    count_d = CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Slot capture, frame publication and timeout; a capture on the
    // completion edge lands in the next frame, and capture beats timeout.
    always_comb begin
        slot_code_d   = slot_code_q;
        slot_dp_d     = slot_dp_q;
        slot_blank_d  = slot_blank_q;
        err_d         = err_q;
        seen_d        = seen_q;
        tcnt_d        = tcnt_q;
        digits_d      = digits_q;
        dp_d          = dp_q;
        blank_d       = blank_q;
        frame_valid_d = 1'b0;
        frame_err_d   = frame_err_q;
        stale_d       = stale_q;

        if (&seen_q) begin
            digits_d      = slot_code_q;
            dp_d          = slot_dp_q;
            blank_d       = slot_blank_q;
            frame_err_d   = |err_q;
            frame_valid_d = 1'b1;
            seen_d        = '0;
            err_d         = '0;
        end

        if (capture) begin
            seen_d = seen_d | an_sel;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (an_sel[i]) begin
                    slot_code_d[4*i +: 4] = dec_bcd;
                    slot_dp_d[i]          = ~s_dp;
                    slot_blank_d[i]       = dec_blank;
                    err_d[i]              = dec_err;
                end
            end
            tcnt_d  = '0;
            stale_d = 1'b0;
        end else begin
            tcnt_d = (tcnt_q == TIMEOUT_MAX) ? tcnt_q : tcnt_q + TW'(1);
            if (tcnt_d == TIMEOUT_MAX) begin
                stale_d = 1'b1;
                seen_d  = '0;
                err_d   = '0;
            end
        end
    end

    // Slot storage, frame outputs and timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_code_q   <= '0;
            slot_dp_q     <= '0;
            slot_blank_q  <= '0;
            err_q         <= '0;
            seen_q        <= '0;
            tcnt_q        <= '0;
            digits_q      <= '0;
            dp_q          <= '0;
            blank_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            slot_code_q   <= slot_code_d;
            slot_dp_q     <= slot_dp_d;
            slot_blank_q  <= slot_blank_d;
            err_q         <= err_d;
            seen_q        <= seen_d;
            tcnt_q        <= tcnt_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            blank_q       <= blank_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            stale_q       <= stale_d;
        end
    end

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign blank       = blank_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (STABLE_CYCLES=4, TIMEOUT_CYCLES=100).
module tb_seg7_scan_decoder;

    // Active-low abcdefg patterns, written out independently of the design.
    localparam logic [6:0] P0 = 7'b0000001;
    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] P4 = 7'b1001100;
    localparam logic [6:0] P5 = 7'b0100100;
    localparam logic [6:0] P6 = 7'b0100000;
    localparam logic [6:0] P7 = 7'b0001111;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0000100;
    localparam logic [6:0] PB = 7'b1111111;
    localparam logic [6:0] PX = 7'b1111110;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        frame_valid;
    logic        frame_err;
    logic        stale;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;
    int fv_count  = 0;
    int base;

    seg7_scan_decoder #(
        .NUM_DIGITS     (4),
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .digits      (digits),
        .dp          (dp),
        .blank       (blank),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    // Count frame_valid pulses away from the active edge.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_count <= fv_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Select one slot with the given pattern and hold it for 'hold' edges.
    task automatic slot(input int idx, input logic [6:0] seg, input logic dpn, input int hold);
        seg_n     = seg;
        dp_n      = dpn;
        an_n      = 4'b1111;
        an_n[idx] = 1'b0;
        ticks(hold);
    endtask

    // Scan slots 3..0 for 10 cycles each; slot 0 capture is on its 5th edge,
    // so frame_valid must be high only after the 6th.
    task automatic scan_frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input logic [3:0] dpn);
        int b;
        b = fv_count;
        slot(3, s3, dpn[3], 10);
        slot(2, s2, dpn[2], 10);
        slot(1, s1, dpn[1], 10);
        slot(0, s0, dpn[0], 5);
        check({tag, "_fv_pre"}, 32'(frame_valid), 0);
        tick();
        check({tag, "_fv"}, 32'(frame_valid), 1);
        tick();
        check({tag, "_fv_post"}, 32'(frame_valid), 0);
        ticks(3);
        check({tag, "_fv_count"}, fv_count - b, 1);
    endtask

    initial begin
        reset = 1'b1;
        seg_n = PB;
        dp_n  = 1'b1;
        an_n  = 4'b1111;
        ticks(3);
        check("rst_digits", 32'(digits), 0);
        check("rst_dp", 32'(dp), 0);
        check("rst_blank", 32'(blank), 0);
        check("rst_fv", 32'(frame_valid), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_stale", 32'(stale), 0);
        reset = 1'b0;

        // Plain "1234"
        scan_frame("s1234", P1, P2, P3, P4, 4'b1111);
        check("s1234_digits", 32'(digits), 32'h1234);
        check("s1234_dp", 32'(dp), 0);
        check("s1234_blank", 32'(blank), 0);
        check("s1234_ferr", 32'(frame_err), 0);
        check("s1234_stale", 32'(stale), 0);

        // Unrecognised pattern on slot 1
        scan_frame("bad1", P1, P2, PX, P4, 4'b1111);
        check("bad1_digits", 32'(digits), 32'h12F4);
        check("bad1_ferr", 32'(frame_err), 1);

        // Blank slot 2, decimal point on slot 0
        scan_frame("blkdp", P5, PB, P7, P8, 4'b1110);
        check("blkdp_digits", 32'(digits), 32'h5F78);
        check("blkdp_blank", 32'(blank), 32'b0100);
        check("blkdp_dp", 32'(dp), 32'b0001);
        check("blkdp_ferr", 32'(frame_err), 0);

        // Glitching slot 0 must not capture until it holds still
        slot(3, P9, 1'b1, 10);
        slot(2, P0, 1'b1, 10);
        slot(1, P6, 1'b1, 10);
        base = fv_count;
        for (int k = 0; k < 10; k++) slot(0, (k % 2 == 0) ? P8 : P0, 1'b1, 3);
        check("glitch_no_capture", fv_count - base, 0);
        slot(0, P2, 1'b1, 5);
        check("glitch_fv_pre", 32'(frame_valid), 0);
        tick();
        check("glitch_fv", 32'(frame_valid), 1);
        tick();
        check("glitch_fv_post", 32'(frame_valid), 0);
        check("glitch_digits", 32'(digits), 32'h9062);
        ticks(3);

        // Invalid anode patterns mid-frame
        base = fv_count;
        slot(3, P4, 1'b1, 10);
        slot(2, P3, 1'b1, 10);
        seg_n = P8;
        an_n  = 4'b0000;
        ticks(25);
        an_n  = 4'b1111;
        ticks(25);
        check("idle_no_frame", fv_count - base, 0);
        check("idle_stale", 32'(stale), 0);
        slot(1, P2, 1'b1, 10);
        slot(0, P1, 1'b1, 10);
        check("idle_fv_count", fv_count - base, 1);
        check("idle_digits", 32'(digits), 32'h4321);
        check("idle_ferr", 32'(frame_err), 0);

        // Timeout: two captures, then a frozen bus
        base = fv_count;
        slot(3, P7, 1'b1, 10);
        slot(2, P7, 1'b1, 5);
        seg_n = P8;
        an_n  = 4'b1111;
        ticks(99);
        check("to_stale_pre", 32'(stale), 0);
        tick();
        check("to_stale", 32'(stale), 1);
        check("to_digits_hold", 32'(digits), 32'h4321);
        slot(1, P6, 1'b1, 4);
        check("to_stale_hold", 32'(stale), 1);
        tick();
        check("to_stale_drop", 32'(stale), 0);
        ticks(5);
        slot(0, P5, 1'b1, 10);
        check("to_discard", fv_count - base, 0);
        slot(3, P8, 1'b1, 10);
        slot(2, P7, 1'b1, 10);
        check("to_fv_count", fv_count - base, 1);
        check("to_digits", 32'(digits), 32'h8765);
        check("to_stale_after", 32'(stale), 0);

        // Capture on the saturation edge keeps stale low
        slot(3, P1, 1'b1, 5);
        seg_n = P8;
        an_n  = 4'b1111;
        ticks(95);
        slot(2, P3, 1'b1, 4);
        check("sat_pre", 32'(stale), 0);
        tick();
        check("capture_wins", 32'(stale), 0);
        ticks(5);
        slot(1, P5, 1'b1, 10);

        // Reset with slots 3..1 seen: partial frame discarded
        reset = 1'b1;
        ticks(2);
        check("mrst_digits", 32'(digits), 0);
        check("mrst_fv", 32'(frame_valid), 0);
        check("mrst_stale", 32'(stale), 0);
        reset = 1'b0;
        base  = fv_count;
        slot(0, P8, 1'b1, 10);
        check("mrst_discard", fv_count - base, 0);
        slot(1, P9, 1'b1, 10);
        slot(1, P6, 1'b1, 10);
        check("reselect_no_frame", fv_count - base, 0);
        slot(3, P2, 1'b1, 10);
        slot(2, P4, 1'b1, 10);
        check("mrst_fv_count", fv_count - base, 1);
        check("mrst_frame_digits", 32'(digits), 32'h2468);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
